loop_sram_ctrl: RTL
===================

Name: loop_sram_ctrl

Overview:
- Looper controller that owns the board SRAM and sequences one SRAM access per audio sample.
- Records the processed effect-chain output into SRAM, then plays the captured loop back continuously with wrap-around.
- Sits between the effect chain output, the top-level FSM key pulse (record/play loop) and the SRAM pins.
- Top level drives the SRAM tristate from o_sram_dq and o_sram_dq_oe.

Parameters:
- ADDR_W, 20, SRAM address width; maximum loop length is 2^ADDR_W samples.
- DATA_W, 16, sample width; signed two's complement.
- ACC_CYC, 2, number of i_clk cycles each SRAM access strobe is held (minimum 1).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sample_valid  in  1  one-cycle pulse marking a new sample
- i_data  in  DATA_W  sample to record (signed)
- i_key  in  1  one-cycle pulse; advances IDLE->REC->PLAY->IDLE
- o_data  out  DATA_W  loop playback sample
- o_valid  out  1  one-cycle pulse when o_data updates
- o_state  out  2  0=IDLE, 1=REC, 2=PLAY
- o_loop_len  out  ADDR_W+1  recorded length in samples
- o_overrun  out  1  sticky flag: a sample_valid was dropped
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_we_n  out  1  SRAM write strobe, active low
- o_sram_oe_n  out  1  SRAM output enable, active low
- o_sram_dq  out  DATA_W  SRAM write data
- o_sram_dq_oe  out  1  1 = drive DQ
- i_sram_dq  in  DATA_W  SRAM read data

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values:
  - o_state=IDLE; o_data=0; o_valid=0; o_loop_len=0; o_overrun=0.
  - o_sram_addr=0; o_sram_we_n=1; o_sram_oe_n=1; o_sram_dq_oe=0; internal address pointer ptr=0.
- Access sequencer: two phases, IDLE_ACC and BUSY. BUSY lasts exactly ACC_CYC cycles, then returns to IDLE_ACC.
  - A sample_valid arriving while BUSY is dropped, o_overrun is set, and no other state changes.
- IDLE state:
  - No SRAM strobes; o_data=0.
  - On i_key: go to REC, ptr=0.
- REC state, write access:
  - On sample_valid: o_sram_addr=ptr, o_sram_dq=i_data (latched), o_sram_dq_oe=1, we_n=0 for ACC_CYC cycles.
  - After the access: we_n=1 and dq_oe=0 in the same cycle, then ptr++.
  - When ptr reaches 2^ADDR_W after a write: automatic transition to PLAY, o_loop_len=2^ADDR_W, ptr=0.
- REC state, i_key:
  - If ptr==0: go to IDLE, loop_len unchanged.
  - Otherwise: o_loop_len=ptr, ptr=0, go to PLAY.
- PLAY state, read access:
  - On sample_valid: o_sram_addr=ptr, oe_n=0 for ACC_CYC cycles.
  - i_sram_dq is captured on the last BUSY cycle.
  - o_data and o_valid update on the next edge. Latency from sample_valid to o_valid is ACC_CYC+1 cycles.
  - ptr wraps: if ptr==o_loop_len-1 then ptr=0, else ptr++.
- PLAY state, i_key: go to IDLE, o_data=0.
- i_key during BUSY:
  - Latched as pending and applied in the cycle BUSY ends, after the ptr update.
  - A second i_key while one is pending is ignored.
- Simultaneous i_key and sample_valid in IDLE_ACC: the key takes effect first. The sample is serviced under the new state in the same cycle. Example: IDLE + key + valid starts the REC write at address 0.
- Reset mid-access: strobes deassert immediately (asynchronous) and the partial access is abandoned.
- No arithmetic beyond counters; ptr is ADDR_W+1 bits wide to hold the full-length value.

Optional Feature:
- Macro: LOOP_OVERDUB_EN.
- Defined:
  - A PLAY access becomes read then write to the same address.
  - Read phase: ACC_CYC cycles with oe_n=0.
  - One turnaround cycle with both strobes high and dq_oe=0.
  - Write phase: ACC_CYC cycles with we_n=0, dq = saturating signed sum of the read data and i_data, clamped to 0x7FFF / 0x8000.
  - o_data is the pre-sum read data, with the same ACC_CYC+1 latency. BUSY lasts 2*ACC_CYC+1 cycles.
- Undefined: PLAY is read-only and no write logic is generated.

Test Plan:
- Basic record and playback: key; samples 0x0011, 0x0022, 0x0033, 0x0044; key; 10 sample_valids.
  - Required: we_n low at addresses 0..3; o_loop_len=4; o_data sequence 0x11,0x22,0x33,0x44,0x11,... each 3 cycles after sample_valid (ACC_CYC=2).
- Empty record: key, then key with no samples.
  - Required: o_state goes 1 then 0; o_loop_len stays 0; no we_n pulse.
- Full-length auto transition: ADDR_W=3, key, 8 samples.
  - Required: o_state=2 automatically; o_loop_len=8; the next read is address 0.
- Overrun and pending key: sample_valid and i_key both asserted 1 cycle after a REC sample_valid.
  - Required: o_overrun=1; that sample is not written; the key applies at BUSY end; o_loop_len=1.
- Reset mid-access: assert i_rst_n low while we_n=0.
  - Required: we_n=1 and dq_oe=0 asynchronously; all outputs at reset values.
- Overdub (LOOP_OVERDUB_EN): stored 0x7000, live input 0x2000.
  - Required: o_data=0x7000; SRAM rewritten with 0x7FFF. Stored 0x9000 with live 0xA000 writes 0x8000.

Source files
------------

// File: rtl/loop_sram_ctrl.sv
// Looper SRAM controller: records effect-chain samples into SRAM, then loops them back.
// Optional overdub (read, turnaround, saturated write-back in PLAY) is enabled by LOOP_OVERDUB_EN.
module loop_sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int ACC_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_key,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_state,
    output logic [ADDR_W:0]   o_loop_len,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    localparam int CNT_W = $clog2(2 * ACC_CYC + 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ACC_CYC - 1);
`ifdef LOOP_OVERDUB_EN
    localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(ACC_CYC);
    localparam logic [CNT_W-1:0] OD_END   = CNT_W'(2 * ACC_CYC);
`endif

    localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOOP_OVERDUB_EN
    // Signed add clamped to the most positive / most negative sample value.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_add = sum[DATA_W-1:0];
        end
    endfunction
`endif

    logic [1:0]        state_r;
    logic [ADDR_W:0]   ptr_r;
    logic [ADDR_W:0]   loop_len_r;
    logic              busy_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              play_acc_r;
    logic              key_pend_r;
    logic [DATA_W-1:0] rd_cap_r;
    logic              out_pend_r;
    logic              overrun_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_n_r;
    logic              oe_n_r;
    logic [DATA_W-1:0] dq_r;
    logic              dq_oe_r;

    logic [CNT_W-1:0]  end_cnt_s;
    logic              acc_end_s;
    logic              key_s;
    logic [1:0]        st_a_s;
    logic [ADDR_W:0]   ptr_a_s;
    logic [ADDR_W:0]   len_a_s;
    logic [1:0]        st_s;
    logic [ADDR_W:0]   ptr_s;
    logic [ADDR_W:0]   len_s;
    logic              clr_s;
    logic              start_s;

    // Access-end pointer update first, then any key (live or pending), then access start.
    always_comb begin
`ifdef LOOP_OVERDUB_EN
        if (play_acc_r) begin
            end_cnt_s = OD_END;
        end else begin
            end_cnt_s = RD_LAST;
        end
`else
        end_cnt_s = RD_LAST;
`endif
        acc_end_s = busy_r && (cnt_r == end_cnt_s);
        st_a_s    = state_r;
        ptr_a_s   = ptr_r;
        len_a_s   = loop_len_r;
        key_s     = 1'b0;
        if (acc_end_s) begin
            key_s = key_pend_r || i_key;
            if (play_acc_r) begin
                ptr_a_s = (ptr_r == loop_len_r - PTR_ONE) ? PTR_ZERO : ptr_r + PTR_ONE;
            end else if (ptr_r + PTR_ONE == FULL_LEN) begin
                st_a_s  = ST_PLAY;
                len_a_s = FULL_LEN;
                ptr_a_s = PTR_ZERO;
            end else begin
                ptr_a_s = ptr_r + PTR_ONE;
            end
        end else if (!busy_r) begin
            key_s = i_key;
        end else begin
            key_s = 1'b0;
        end

        st_s  = st_a_s;
        ptr_s = ptr_a_s;
        len_s = len_a_s;
        clr_s = 1'b0;
        if (key_s) begin
            case (st_a_s)
                ST_IDLE: begin
                    st_s  = ST_REC;
                    ptr_s = PTR_ZERO;
                end
                ST_REC: begin
                    if (ptr_a_s == PTR_ZERO) begin
                        st_s = ST_IDLE;
                    end else begin
                        len_s = ptr_a_s;
                        ptr_s = PTR_ZERO;
                        st_s  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    st_s  = ST_IDLE;
                    clr_s = 1'b1;
                end
                default: begin
                    st_s = ST_IDLE;
                end
            endcase
        end else begin
            st_s = st_a_s;
        end
        start_s = !busy_r && i_sample_valid && ((st_s == ST_REC) || (st_s == ST_PLAY));
    end

    // Control state, access sequencer and SRAM strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_ZERO;
            loop_len_r <= PTR_ZERO;
            busy_r     <= 1'b0;
            cnt_r      <= CNT_ZERO;
            play_acc_r <= 1'b0;
            key_pend_r <= 1'b0;
            rd_cap_r   <= {DATA_W{1'b0}};
            out_pend_r <= 1'b0;
            overrun_r  <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            we_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            dq_r       <= {DATA_W{1'b0}};
            dq_oe_r    <= 1'b0;
        end else begin
            state_r    <= st_s;
            ptr_r      <= ptr_s;
            loop_len_r <= len_s;
            out_pend_r <= 1'b0;
            if (busy_r && i_sample_valid) begin
                overrun_r <= 1'b1;
            end
            if (acc_end_s) begin
                key_pend_r <= 1'b0;
            end else if (busy_r && i_key) begin
                key_pend_r <= 1'b1;
            end
            if (start_s) begin
                busy_r     <= 1'b1;
                cnt_r      <= CNT_ZERO;
                play_acc_r <= (st_s == ST_PLAY);
                addr_r     <= ptr_s[ADDR_W-1:0];
                if (st_s == ST_REC) begin
                    we_n_r  <= 1'b0;
                    dq_r    <= i_data;
                    dq_oe_r <= 1'b1;
                end else begin
                    oe_n_r  <= 1'b0;
`ifdef LOOP_OVERDUB_EN
                    dq_r    <= i_data;
`endif
                end
            end else if (acc_end_s) begin
                busy_r  <= 1'b0;
                cnt_r   <= CNT_ZERO;
                we_n_r  <= 1'b1;
                oe_n_r  <= 1'b1;
                dq_oe_r <= 1'b0;
`ifndef LOOP_OVERDUB_EN
                if (play_acc_r) begin
                    rd_cap_r   <= i_sram_dq;
                    out_pend_r <= 1'b1;
                end
`endif
            end else if (busy_r) begin
                cnt_r <= cnt_r + CNT_ONE;
`ifdef LOOP_OVERDUB_EN
                // Read ends, one idle turnaround cycle, then write back the mixed sample.
                if (play_acc_r && (cnt_r == RD_LAST)) begin
                    rd_cap_r   <= i_sram_dq;
                    out_pend_r <= 1'b1;
                    oe_n_r     <= 1'b1;
                end else if (play_acc_r && (cnt_r == WR_FIRST)) begin
                    we_n_r  <= 1'b0;
                    dq_r    <= sat_add(rd_cap_r, dq_r);
                    dq_oe_r <= 1'b1;
                end
`endif
            end
        end
    end

    // Playback output register; leaving PLAY forces silence.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (clr_s) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (out_pend_r && (state_r == ST_PLAY)) begin
            data_r  <= rd_cap_r;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign o_data       = data_r;
    assign o_valid      = valid_r;
    assign o_state      = state_r;
    assign o_loop_len   = loop_len_r;
    assign o_overrun    = overrun_r;
    assign o_sram_addr  = addr_r;
    assign o_sram_we_n  = we_n_r;
    assign o_sram_oe_n  = oe_n_r;
    assign o_sram_dq    = dq_r;
    assign o_sram_dq_oe = dq_oe_r;

endmodule
